program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Write side of the 64 x 19-bit instruction memory read by the fetch/split/ALU path.
//  Receives a byte stream over a valid/ready handshake.
//  Packs every 3 bytes into one 19-bit instruction {op[2:0], a[7:0], b[7:0]}.
//  Writes the words to sequential addresses starting at 0, then pulses done.
// PARAMETERS
//  ADDR_W  6   instruction memory address width
//  DEPTH   64  number of instruction words; max load length
//  WORD_W  19  instruction width (3-bit op + 8-bit a + 8-bit b)
// PORTS
//  clk        in   1       single clock; all logic on rising edge
//  rst_n      in   1       synchronous, active-low reset
//  start      in   1       1-cycle request to begin a load; sampled only in IDLE
//  len        in   7       words to load, 1..DEPTH; sampled with start
//  in_valid   in   1       byte available on in_data
//  in_data    in   8       stream byte
//  in_ready   out  1       loader accepts a byte this cycle
//  mem_we     out  1       instruction memory write strobe
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  WORD_W  write data
//  busy       out  1       load in progress (not IDLE)
//  done       out  1       1-cycle pulse after the last word is written
//  err        out  1       sticky format/length error; cleared by next accepted start
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE.
//   Outputs in_ready, mem_we, busy, done and err are 0.
//   mem_addr and mem_wdata are 0.
//   Word counter and byte buffers are cleared.
//  Handshake: a byte transfers on a clk edge where in_valid & in_ready.
//   in_ready depends only on state, never on in_valid.
//  FSM states: IDLE, B0, B1, B2, WR, FIN.
//   IDLE: start & 1<=len<=DEPTH -> B0. Latches len, clears counter, clears err.
//         start & (len==0 | len>DEPTH) -> stays IDLE, err=1, no writes.
//   B0: in_ready=1; on transfer latch op=in_data[2:0] -> B1.
//       If in_data[7:3]!=0 set err; the load continues with those bits dropped.
//   B1: in_ready=1; on transfer latch a=in_data -> B2.
//   B2: in_ready=1; on transfer latch b=in_data -> WR.
//   WR: in_ready=0, mem_we=1 for exactly 1 cycle.
//       mem_addr=counter, mem_wdata={op,a,b}.
//       Then counter==len-1 -> FIN; else counter+1 -> B0.
//   FIN: done=1 for exactly 1 cycle -> IDLE.
//  Latency: mem_we is high the cycle after the 3rd byte transfer.
//   Back-to-back load time is 4 cycles/word minimum.
//  busy=1 in every state except IDLE. start while busy is ignored.
//  Stalls (in_valid=0) hold state and all latched data indefinitely.
//  Address never wraps: at most len<=DEPTH writes, addresses 0..len-1 in order.
//  mem_addr/mem_wdata hold their last value outside WR.
//  Reset mid-load: abort at once; no partial word is written; done is not pulsed.
//  err is never cleared by a successful load; only by reset or the next accepted start.
// TESTING
//  1. len=2; bytes 01,71,13,00,03,4C -> WR addr0=19'h17113, addr1=19'h0034C; done pulse; 8 cycles min.
//  2. len=1; in_valid toggled every other cycle -> single write of correct word; no early mem_we.
//  3. len=0, then len=65 -> no writes, err=1, busy stays 0; next valid start clears err.
//  4. byte0=8'hF9 -> op=3'b001 written, err=1 after load, done still pulses.
//  5. len=64, full stream -> addresses 0..63 written once each, no wrap; done after addr 63.
//  6. rst_n low after 2 bytes of word 5 -> outputs return to reset values; no write to addr 5;
//     a new load starts at addr 0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader - packs a 3-byte-per-word stream into sequential instruction memory writes
// Each word is {op[2:0], a[7:0], b[7:0]}; stray op high bits are dropped and flagged in err.
module program_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int WORD_W = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [6:0]        len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [6:0] DEPTH_L = 7'(DEPTH);
  localparam logic [6:0] ONE_L   = 7'd1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_B0   = 3'd1,
    S_B1   = 3'd2,
    S_B2   = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [6:0]          len_q, len_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [7:0]          a_q, a_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                len_ok;
  logic                xfer;
  logic                last_word;
  logic [6:0]          len_m1;

  assign len_ok    = (len != 7'd0) && (len <= DEPTH_L);
  assign xfer      = in_valid && in_ready;
  assign len_m1    = len_q - ONE_L;
  assign last_word = (7'(cnt_q) == len_m1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && len_ok) state_d = S_B0;
      S_B0:   if (in_valid) state_d = S_B1;
      S_B1:   if (in_valid) state_d = S_B2;
      S_B2:   if (in_valid) state_d = S_WR;
      S_WR:   state_d = last_word ? S_FIN : S_B0;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_B0, S_B1, S_B2: in_ready = 1'b1;
      S_WR:   mem_we = 1'b1;
      S_FIN:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Address/data are captured on the third byte so they are stable through WR and held afterwards.
  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d = len;
            cnt_d = '0;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_B0: begin
        if (xfer) begin
          op_d = in_data[2:0];
          if (in_data[7:3] != 5'd0) err_d = 1'b1;
        end
      end
      S_B1: begin
        if (xfer) a_d = in_data;
      end
      S_B2: begin
        if (xfer) begin
          addr_d  = cnt_q;
          wdata_d = {op_q, a_q, in_data};
        end
      end
      S_WR: begin
        if (!last_word) cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
// Writes and done pulses are logged on the falling edge and compared with hand-computed words.
`timescale 1ns/1ps
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [18:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  program_loader #(.ADDR_W(6), .DEPTH(64), .WORD_W(19)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t_start = 0;
  int t_done  = 0;
  int done_cnt = 0;
  int wr_at_done = 0;
  int busy_cnt = 0;
  logic [5:0]  wr_addr[$];
  logic [18:0] wr_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (done) begin
      done_cnt   = done_cnt + 1;
      t_done     = cyc;
      wr_at_done = wr_addr.size();
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    int n;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    if (!ok) check("send_byte_timeout", 32'(n), 32'd0);
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit gap);
    send_byte(b0, gap);
    send_byte(b1, gap);
    send_byte(b2, gap);
  endtask

  task automatic do_start(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start   = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_addr",     32'(mem_addr), 32'd0);
    check("rst_wdata",    32'(mem_wdata),32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two words back to back, minimum latency
    clear_log();
    do_start(7'd2);
    send_word(8'h01, 8'h71, 8'h13, 1'b0);
    send_word(8'h00, 8'h03, 8'h4C, 1'b0);
    wait_done();
    check("t1_nwr",   32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("t1_addr0", 32'(wr_addr[0]), 32'd0);
      check("t1_data0", 32'(wr_data[0]), 32'h17113);
      check("t1_addr1", 32'(wr_addr[1]), 32'd1);
      check("t1_data1", 32'(wr_data[1]), 32'h0034C);
    end
    check("t1_cycles", 32'(t_done - t_start), 32'd8);
    check("t1_err",    32'(err), 32'd0);

    // 2: stalled stream, no early write, write the cycle after the last byte
    clear_log();
    do_start(7'd1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hA5, 1'b1);
    check("t2_no_early", 32'(wr_addr.size()), 32'd0);
    send_byte(8'h5A, 1'b1);
    @(negedge clk);
    check("t2_we_lat", 32'(mem_we), 32'd1);
    check("t2_data",   32'(mem_wdata), 32'h5A55A);
    @(posedge clk); #1;
    wait_done();
    check("t2_nwr", 32'(wr_addr.size()), 32'd1);
    check("t2_hold", 32'(mem_wdata), 32'h5A55A);

    // 3: illegal lengths
    clear_log();
    do_start(7'd0);
    @(negedge clk);
    check("t3_err0",  32'(err),  32'd1);
    check("t3_busy0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    do_start(7'd65);
    @(negedge clk);
    check("t3_err65",  32'(err),  32'd1);
    check("t3_busy65", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("t3_nwr",     32'(wr_addr.size()), 32'd0);
    check("t3_busycnt", 32'(busy_cnt), 32'd0);
    do_start(7'd1);
    @(negedge clk);
    check("t3_err_clr", 32'(err), 32'd0);
    @(posedge clk); #1;
    send_word(8'h07, 8'hFF, 8'h00, 1'b0);
    wait_done();
    check("t3_data", 32'(wr_data.size() == 1 ? wr_data[0] : 19'h0), 32'h7FF00);

    // 4: op byte with stray high bits
    clear_log();
    do_start(7'd1);
    send_word(8'hF9, 8'h12, 8'h34, 1'b0);
    wait_done();
    check("t4_data", 32'(wr_data.size() == 1 ? wr_data[0] : 19'h0), 32'h11234);
    check("t4_err",  32'(err), 32'd1);

    // 5: full depth, addresses 0..63 exactly once
    clear_log();
    do_start(7'd64);
    for (int i = 0; i < 64; i++) send_word(8'(i % 8), 8'(i), ~8'(i), 1'b0);
    wait_done();
    check("t5_nwr", 32'(wr_addr.size()), 32'd64);
    check("t5_wr_at_done", 32'(wr_at_done), 32'd64);
    check("t5_err", 32'(err), 32'd0);
    if (wr_addr.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        check($sformatf("t5_addr%0d", i), 32'(wr_addr[i]), 32'(i));
        check($sformatf("t5_data%0d", i), 32'(wr_data[i]), 32'({3'(i % 8), 8'(i), ~8'(i)}));
      end
    end

    // 6: reset after two bytes of word 5
    clear_log();
    do_start(7'd8);
    for (int i = 0; i < 5; i++) send_word(8'h02, 8'(8'h10 + i), 8'h20, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h44, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_mem_we",   32'(mem_we),   32'd0);
    check("t6_busy",     32'(busy),     32'd0);
    check("t6_addr",     32'(mem_addr), 32'd0);
    check("t6_wdata",    32'(mem_wdata),32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_nwr",  32'(wr_addr.size()), 32'd5);
    check("t6_done", 32'(done_cnt), 32'd0);
    if (wr_addr.size() == 5) check("t6_last_addr", 32'(wr_addr[4]), 32'd4);
    clear_log();
    do_start(7'd1);
    send_word(8'h06, 8'hAB, 8'hCD, 1'b0);
    wait_done();
    check("t6_new_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("t6_new_addr", 32'(wr_addr[0]), 32'd0);
      check("t6_new_data", 32'(wr_data[0]), 32'h6ABCD);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
